// File: rtl/stopwatch_ctrl_pkg.sv
// stopwatch_pkg: state encoding and small helpers shared by the stopwatch control unit.
//   sw_state_e  : 2-bit FSM state (IDLE=00, RUN=01, LAP=10, PAUSE=11)
//   is_counting : 1 when the prescaler advances in the given state (RUN or LAP)
package stopwatch_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_LAP   = 2'b10,
        ST_PAUSE = 2'b11
    } sw_state_e;

    // The chain counts in RUN and in LAP; LAP only freezes the display.
    function automatic logic is_counting(sw_state_e s);
        return (s == ST_RUN) || (s == ST_LAP);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: button inputs and counter-chain controls of the stopwatch control unit.
//   btn_ss    : raw start/stop button (async, active-high)
//   btn_lr    : raw lap/reset button (async, active-high)
//   tick_en   : one-cycle count-enable pulse to the counter chain
//   cnt_clr   : one-cycle synchronous clear to the counter chain
//   disp_hold : display latch frozen (lap view)
//   state     : current FSM state
// master = board/button side, slave = the control unit.
interface stopwatch_ctrl_if;
    import stopwatch_pkg::*;

    logic               btn_ss;
    logic               btn_lr;
    logic               tick_en;
    logic               cnt_clr;
    logic               disp_hold;
    logic [STATE_W-1:0] state;

    modport master (
        output btn_ss,
        output btn_lr,
        input  tick_en,
        input  cnt_clr,
        input  disp_hold,
        input  state
    );

    modport slave (
        input  btn_ss,
        input  btn_lr,
        output tick_en,
        output cnt_clr,
        output disp_hold,
        output state
    );

endinterface

// File: rtl/stopwatch_ctrl_btn_cond.sv
// btn_cond: conditions one raw push-button.
//   2-flop synchronizer -> debounce counter -> one-cycle press pulse on the debounced 0->1 edge.
//   A button already held when reset is released is ignored until it has been seen released
//   (synchronized low for DB_CYCLES consecutive cycles).
// Ports:
//   clk   : system clock
//   r     : synchronous active-low reset
//   raw   : asynchronous button level
//   press : one-cycle press pulse (registered)
module btn_cond #(
    parameter int unsigned DB_CYCLES = 20
) (
    input  logic clk,
    input  logic r,
    input  logic raw,
    output logic press
);

    localparam int unsigned           CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);

    logic [1:0]       sync_q;
    logic [1:0]       vld_q;
    logic             level_q;
    logic [CNT_W-1:0] db_cnt_q;
    logic [CNT_W-1:0] rel_cnt_q;
    logic             armed_q;
    logic             seen;
    logic             seen_vld;

    // Synchronized level and whether it already reflects a post-reset sample.
    assign seen     = sync_q[1];
    assign seen_vld = vld_q[1];

    // Synchronizer, debounce and press generation.
    always_ff @(posedge clk) begin
        if (!r) begin
            sync_q    <= '0;
            vld_q     <= '0;
            level_q   <= 1'b0;
            db_cnt_q  <= '0;
            rel_cnt_q <= '0;
            armed_q   <= 1'b0;
            press     <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            vld_q  <= {vld_q[0], 1'b1};
            press  <= 1'b0;

            // Level follows only after DB_CYCLES consecutive differing samples.
            if (seen != level_q) begin
                if (db_cnt_q == CNT_LAST) begin
                    level_q  <= seen;
                    db_cnt_q <= '0;
                    press    <= seen & armed_q;
                end else begin
                    db_cnt_q <= db_cnt_q + CNT_ONE;
                end
            end else begin
                db_cnt_q <= '0;
            end

            // Arm once the button has been seen cleanly released after reset.
            if (!armed_q && seen_vld && !seen) begin
                if (rel_cnt_q == CNT_LAST) begin
                    armed_q   <= 1'b1;
                    rel_cnt_q <= '0;
                end else begin
                    rel_cnt_q <= rel_cnt_q + CNT_ONE;
                end
            end else begin
                rel_cnt_q <= '0;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: control unit for the stopwatch counter chain.
//   Conditions the start/stop and lap/reset buttons, runs the IDLE/RUN/LAP/PAUSE machine and
//   the count prescaler, and drives the chain's count enable, clear and display hold.
// Parameters:
//   CLK_DIV   : clock cycles per count tick (>= 2)
//   DB_CYCLES : stable cycles before a button level is accepted (>= 1)
// Ports:
//   clk : system clock
//   r   : synchronous active-low reset
//   bus : stopwatch_ctrl_if.slave (btn_ss, btn_lr in; tick_en, cnt_clr, disp_hold, state out)
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 500000,
    parameter int unsigned DB_CYCLES = 20
) (
    input  logic               clk,
    input  logic               r,
    stopwatch_ctrl_if.slave    bus
);

    localparam int unsigned      PRE_W    = $clog2(CLK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

    sw_state_e        state_q;
    sw_state_e        state_nxt;
    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_nxt;
    logic             clr_nxt;
    logic             tick_q;
    logic             clr_q;
    logic             hold_q;
    logic             ss_p;
    logic             lr_p;

    // Button conditioning.
    btn_cond #(.DB_CYCLES(DB_CYCLES)) u_btn_ss (
        .clk   (clk),
        .r     (r),
        .raw   (bus.btn_ss),
        .press (ss_p)
    );

    btn_cond #(.DB_CYCLES(DB_CYCLES)) u_btn_lr (
        .clk   (clk),
        .r     (r),
        .raw   (bus.btn_lr),
        .press (lr_p)
    );

    // Next state, prescaler and clear request; start/stop wins over lap/reset.
    always_comb begin
        state_nxt = state_q;
        pre_nxt   = pre_q;
        clr_nxt   = 1'b0;

        case (state_q)
            ST_IDLE:        pre_nxt = '0;
            ST_RUN, ST_LAP: pre_nxt = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_ONE;
            default:        pre_nxt = pre_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (ss_p) begin
                    state_nxt = ST_RUN;
                end else if (lr_p) begin
                    clr_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                if (ss_p) begin
                    state_nxt = ST_PAUSE;
                end else if (lr_p) begin
                    state_nxt = ST_LAP;
                end
            end
            ST_LAP: begin
                if (ss_p) begin
                    state_nxt = ST_PAUSE;
                end else if (lr_p) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_PAUSE: begin
                // Resume keeps the held prescaler phase; reset discards it.
                if (ss_p) begin
                    state_nxt = ST_RUN;
                end else if (lr_p) begin
                    state_nxt = ST_IDLE;
                    clr_nxt   = 1'b1;
                    pre_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, prescaler and output registers. Outputs are registered from the next-state
    // values, so they equal the decode of the current state and prescaler each cycle.
    always_ff @(posedge clk) begin
        if (!r) begin
            state_q <= ST_IDLE;
            pre_q   <= '0;
            tick_q  <= 1'b0;
            clr_q   <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            pre_q   <= pre_nxt;
            clr_q   <= clr_nxt;
            hold_q  <= (state_nxt == ST_LAP);
            tick_q  <= is_counting(state_nxt) && (pre_nxt == PRE_LAST);
        end
    end

    assign bus.tick_en   = tick_q;
    assign bus.cnt_clr   = clr_q;
    assign bus.disp_hold = hold_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed bench for stopwatch_ctrl with CLK_DIV=4, DB_CYCLES=3.
// A cycle-level behavioural model predicts every output each cycle; literal checks at
// hand-computed cycles pin the model to the expected timing.
module tb_stopwatch_ctrl;

    localparam int unsigned CLK_DIV = 4;
    localparam int          DB      = 3;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_LAP   = 2;
    localparam int M_PAUSE = 3;

    logic clk = 1'b0;
    logic r;

    stopwatch_ctrl_if bus ();

    stopwatch_ctrl #(
        .CLK_DIV   (CLK_DIV),
        .DB_CYCLES (DB)
    ) dut (
        .clk (clk),
        .r   (r),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [1:0] pipe;      // raw samples still travelling through the synchronizer
        int         age;       // edges since reset, saturating at 2
        logic       lvl;       // accepted button level
        int         diff_run;  // consecutive samples differing from lvl
        int         low_run;   // consecutive released samples before arming
        bit         armed;
        bit         press;     // press pulse visible this cycle
    } btn_m_t;

    typedef struct {
        btn_m_t ss;
        btn_m_t lr;
        int     st;
        int     phase;         // counted cycles since last restart
        bit     clr;
    } mdl_t;

    function automatic btn_m_t btn_reset();
        btn_m_t n;
        n.pipe = 2'b00; n.age = 0; n.lvl = 1'b0; n.diff_run = 0;
        n.low_run = 0; n.armed = 1'b0; n.press = 1'b0;
        return n;
    endfunction

    function automatic btn_m_t btn_step(btn_m_t b, logic raw);
        btn_m_t n;
        logic   seen;
        n       = b;
        seen    = b.pipe[1];
        n.press = 1'b0;
        if (seen != b.lvl) begin
            n.diff_run = b.diff_run + 1;
            if (n.diff_run == DB) begin
                n.lvl      = seen;
                n.diff_run = 0;
                n.press    = seen && b.armed;
            end
        end else begin
            n.diff_run = 0;
        end
        if (!b.armed && b.age >= 2 && !seen) begin
            n.low_run = b.low_run + 1;
            if (n.low_run == DB) n.armed = 1'b1;
        end else begin
            n.low_run = 0;
        end
        n.pipe = {b.pipe[0], raw};
        if (b.age < 2) n.age = b.age + 1;
        return n;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, logic rn, logic ss, logic lr);
        mdl_t n;
        n = m;
        if (!rn) begin
            n.ss = btn_reset(); n.lr = btn_reset();
            n.st = M_IDLE; n.phase = 0; n.clr = 1'b0;
            return n;
        end
        n.ss  = btn_step(m.ss, ss);
        n.lr  = btn_step(m.lr, lr);
        n.clr = 1'b0;
        if (m.st == M_IDLE) n.phase = 0;
        else if (m.st == M_RUN || m.st == M_LAP) n.phase = m.phase + 1;
        if (m.ss.press) begin
            n.st = (m.st == M_RUN || m.st == M_LAP) ? M_PAUSE : M_RUN;
        end else if (m.lr.press) begin
            case (m.st)
                M_IDLE:  n.clr = 1'b1;
                M_RUN:   n.st = M_LAP;
                M_LAP:   n.st = M_RUN;
                default: begin n.st = M_IDLE; n.clr = 1'b1; n.phase = 0; end
            endcase
        end
        return n;
    endfunction

    mdl_t m;
    bit   m_ok = 1'b0;

    always @(posedge clk) begin
        m <= mdl_step(m, r, bus.btn_ss, bus.btn_lr);
        if (!r) m_ok <= 1'b1;
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_ok) begin
            check("state", int'(bus.state), m.st);
            check("disp_hold", int'(bus.disp_hold), (m.st == M_LAP) ? 1 : 0);
            check("cnt_clr", int'(bus.cnt_clr), int'(m.clr));
            check("tick_en", int'(bus.tick_en),
                  ((m.st == M_RUN || m.st == M_LAP) &&
                   (m.phase % int'(CLK_DIV) == int'(CLK_DIV) - 1)) ? 1 : 0);
        end
    end

    // ---------------- directed stimulus ----------------
    int k_now;

    task automatic goto_k(input int k);
        while (k_now < k) begin
            @(negedge clk);
            k_now++;
        end
    endtask

    initial begin
        r          = 1'b0;
        bus.btn_ss = 1'b1;
        bus.btn_lr = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_state", int'(bus.state), 0);
        check("rst_tick", int'(bus.tick_en), 0);
        check("rst_clr", int'(bus.cnt_clr), 0);
        check("rst_hold", int'(bus.disp_hold), 0);

        // Buttons held through reset release: no press may result.
        r = 1'b1;
        repeat (10) @(negedge clk);
        check("held_no_start", int'(bus.state), 0);
        bus.btn_ss = 1'b0;
        bus.btn_lr = 1'b0;
        repeat (10) @(negedge clk);
        check("held_release_idle", int'(bus.state), 0);

        // Bounce: 2 high / 2 low never survives the 3-cycle filter.
        for (int i = 0; i < 20; i++) begin
            bus.btn_ss = ((i / 2) % 2 == 0);
            @(negedge clk);
        end
        bus.btn_ss = 1'b0;
        repeat (6) @(negedge clk);
        check("bounce_idle", int'(bus.state), 0);

        // Timeline relative to the start press (k = cycle index from the raw edge).
        k_now = 0;
        bus.btn_ss = 1'b1;
        goto_k(5);  check("start_not_yet", int'(bus.state), 0);
        goto_k(6);  check("start_run", int'(bus.state), 1);
        goto_k(8);  check("run_tick_c3", int'(bus.tick_en), 0);
        goto_k(9);  check("run_tick_c4", int'(bus.tick_en), 1);
        goto_k(10); bus.btn_ss = 1'b0;
        goto_k(13); check("run_tick_c8", int'(bus.tick_en), 1);

        // Lap in, then lap out.
        goto_k(14); bus.btn_lr = 1'b1;
        goto_k(18); bus.btn_lr = 1'b0;
        goto_k(19); check("lap_not_yet", int'(bus.state), 1);
        goto_k(20); check("lap_state", int'(bus.state), 2);
                    check("lap_hold", int'(bus.disp_hold), 1);
        goto_k(21); check("lap_tick", int'(bus.tick_en), 1);
        goto_k(25); check("lap_tick2", int'(bus.tick_en), 1);
        goto_k(26); bus.btn_lr = 1'b1;
        goto_k(30); bus.btn_lr = 1'b0;
        goto_k(32); check("unlap_state", int'(bus.state), 1);
                    check("unlap_hold", int'(bus.disp_hold), 0);
        goto_k(33); check("unlap_tick", int'(bus.tick_en), 1);

        // Pause with held phase 2, then resume.
        goto_k(38); bus.btn_ss = 1'b1;
        goto_k(42); bus.btn_ss = 1'b0;
        goto_k(44); check("pause_state", int'(bus.state), 3);
        goto_k(45); check("pause_no_tick", int'(bus.tick_en), 0);
        goto_k(50); bus.btn_ss = 1'b1;
        goto_k(54); bus.btn_ss = 1'b0;
        goto_k(56); check("resume_state", int'(bus.state), 1);
                    check("resume_tick_c1", int'(bus.tick_en), 0);
        goto_k(57); check("resume_tick_c2", int'(bus.tick_en), 1);

        // Pause again, then clear from PAUSE.
        goto_k(60); bus.btn_ss = 1'b1;
        goto_k(64); bus.btn_ss = 1'b0;
        goto_k(66); check("pause2_state", int'(bus.state), 3);
        goto_k(70); bus.btn_lr = 1'b1;
        goto_k(74); bus.btn_lr = 1'b0;
        goto_k(75); check("clr_before", int'(bus.cnt_clr), 0);
        goto_k(76); check("clr_state", int'(bus.state), 0);
                    check("clr_pulse", int'(bus.cnt_clr), 1);
        goto_k(77); check("clr_after", int'(bus.cnt_clr), 0);

        // Restart from IDLE: prescaler restarts from zero.
        goto_k(80); bus.btn_ss = 1'b1;
        goto_k(84); bus.btn_ss = 1'b0;
        goto_k(86); check("restart_run", int'(bus.state), 1);
        goto_k(88); check("restart_tick_c3", int'(bus.tick_en), 0);
        goto_k(89); check("restart_tick_c4", int'(bus.tick_en), 1);

        // Both buttons together in RUN: start/stop wins, lap is dropped.
        goto_k(92); bus.btn_ss = 1'b1; bus.btn_lr = 1'b1;
        goto_k(96); bus.btn_ss = 1'b0; bus.btn_lr = 1'b0;
        goto_k(97); check("both_before", int'(bus.state), 1);
        goto_k(98); check("both_pause", int'(bus.state), 3);
                    check("both_no_hold", int'(bus.disp_hold), 0);
        goto_k(99); check("both_stay", int'(bus.state), 3);

        // Mid-operation reset.
        goto_k(104); r = 1'b0;
        goto_k(105); check("midrst_state", int'(bus.state), 0);
        goto_k(106); r = 1'b1;
        goto_k(112);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
